rob_multi_commit: RTL and testbench

ROB_MULTI_COMMIT -- requirements
Module: rob_multi_commit

---
 rtl/rob_pkg.sv | 28 ++
 rtl/rob_commit_select.sv | 33 +++
 rtl/rob_multi_commit.sv | 218 +++++++++++++++++++++
 tb/tb_rob_multi_commit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// rob_pkg: shared constants and entry layout for the multi-commit reorder buffer.
//   Default geometry: 64 entries, 2 retirements/cycle, 2 writeback ports.
//   rob_entry_t field widths follow the ROB_*_W constants. A wider or narrower
//   instance must change these constants as well as its own parameters.
package rob_pkg;

    localparam int ROB_DEPTH    = 64;
    localparam int ROB_COMMIT_W = 2;
    localparam int ROB_WB_PORTS = 2;
    localparam int ROB_ARCH_W   = 5;
    localparam int ROB_PHYS_W   = 6;
    localparam int ROB_PC_W     = 32;

    typedef struct packed {
        logic                  valid;
        logic                  executed;
        logic                  sys;
        logic                  redirect;
        logic                  load;
        logic                  store;
        logic                  reg_write;
        logic [ROB_ARCH_W-1:0] arch;
        logic [ROB_PHYS_W-1:0] phys;
        logic [ROB_PC_W-1:0]   pc;
        logic [ROB_PC_W-1:0]   alt_pc;
    } rob_entry_t;

endpackage

// File: rtl/rob_commit_select.sv
// rob_commit_select: chooses which of the oldest COMMIT_W entries retire this cycle.
//   valid_i/exec_i : per-slot valid and executed flags, slot 0 = head
//   spec_i         : per-slot sys-or-redirect flag
//   retire_o       : per-slot retire qualification (always a contiguous prefix)
//   num_o          : number of slots retiring
module rob_commit_select
    import rob_pkg::*;
#(
    parameter int COMMIT_W = ROB_COMMIT_W
) (
    input  logic [COMMIT_W-1:0] valid_i,
    input  logic [COMMIT_W-1:0] exec_i,
    input  logic [COMMIT_W-1:0] spec_i,
    output logic [COMMIT_W-1:0] retire_o,
    output logic [1:0]          num_o
);

    logic ok;

    // A sys/redirect entry may only go out alone from slot 0, and it stops
    // every slot behind it.
    always_comb begin
        ok = 1'b1;
        num_o = '0;
        retire_o = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            retire_o[k] = ok && valid_i[k] && exec_i[k] && (k == 0 || !spec_i[k]);
            ok = retire_o[k] && !spec_i[k];
            num_o = num_o + 2'(retire_o[k]);
        end
    end

endmodule

// File: rtl/rob_multi_commit.sv
// rob_multi_commit: in-order reorder buffer with up to COMMIT_W retirements per cycle.
//   alloc_*  : allocate one entry at the tail; alloc_tag_o is the granted slot
//   wb_*     : WB_PORTS writeback channels marking entries executed, optionally
//              with a redirect target
//   commit_* : registered retirement record, one lane per slot
//   flush_in_i          : external squash of everything, silent (no flush_out_o)
//   flush_out_o/mem_flush_o/redirect_* : one-cycle pulse after a sys/redirect retires
//   head_store_o, count_o : head-entry store flag and occupancy
module rob_multi_commit
    import rob_pkg::*;
#(
    parameter int   DEPTH    = ROB_DEPTH,
    parameter int   COMMIT_W = ROB_COMMIT_W,
    parameter int   WB_PORTS = ROB_WB_PORTS,
    parameter int   ARCH_W   = ROB_ARCH_W,
    parameter int   PHYS_W   = ROB_PHYS_W,
    parameter int   PC_W     = ROB_PC_W,
    localparam int  TAG_W    = $clog2(DEPTH)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       alloc_valid_i,
    output logic                       alloc_ready_o,
    input  logic                       alloc_reg_write_i,
    input  logic [ARCH_W-1:0]          alloc_arch_i,
    input  logic [PHYS_W-1:0]          alloc_phys_i,
    input  logic [PC_W-1:0]            alloc_pc_i,
    input  logic                       alloc_sys_i,
    input  logic                       alloc_load_i,
    input  logic                       alloc_store_i,
    output logic [TAG_W-1:0]           alloc_tag_o,
    input  logic [WB_PORTS-1:0]        wb_valid_i,
    input  logic [WB_PORTS*TAG_W-1:0]  wb_tag_i,
    input  logic [WB_PORTS-1:0]        wb_redirect_i,
    input  logic [WB_PORTS*PC_W-1:0]   wb_alt_pc_i,
    output logic [COMMIT_W-1:0]        commit_valid_o,
    output logic [COMMIT_W-1:0]        commit_reg_write_o,
    output logic [COMMIT_W*ARCH_W-1:0] commit_arch_o,
    output logic [COMMIT_W*PHYS_W-1:0] commit_phys_o,
    output logic [COMMIT_W*PC_W-1:0]   commit_pc_o,
    input  logic                       flush_in_i,
    output logic                       flush_out_o,
    output logic                       mem_flush_o,
    output logic                       redirect_valid_o,
    output logic [PC_W-1:0]            redirect_pc_o,
    output logic                       head_store_o,
    output logic [TAG_W:0]             count_o
);

    logic [TAG_W-1:0]           head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]             count_q, count_d;
    rob_entry_t                 ent_q [DEPTH];
    rob_entry_t                 ent_d [DEPTH];
    logic [COMMIT_W-1:0]        commit_valid_q, commit_valid_d;
    logic [COMMIT_W-1:0]        commit_reg_write_q, commit_reg_write_d;
    logic [COMMIT_W*ARCH_W-1:0] commit_arch_q, commit_arch_d;
    logic [COMMIT_W*PHYS_W-1:0] commit_phys_q, commit_phys_d;
    logic [COMMIT_W*PC_W-1:0]   commit_pc_q, commit_pc_d;
    logic                       flush_out_q, flush_out_d;
    logic                       mem_flush_q, mem_flush_d;
    logic                       redirect_valid_q, redirect_valid_d;
    logic [PC_W-1:0]            redirect_pc_q, redirect_pc_d;

    logic [TAG_W-1:0]    slot_idx [COMMIT_W];
    logic [COMMIT_W-1:0] slot_valid, slot_exec, slot_spec, retire;
    logic [1:0]          retire_num;
    logic                alloc_fire, squash, wb_win;
    logic [TAG_W-1:0]    wb_t;

    assign alloc_ready_o = (count_q != (TAG_W+1)'(DEPTH)) && !flush_out_q;
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;
    assign alloc_tag_o   = tail_q;
    assign count_o       = count_q;
    assign head_store_o  = ent_q[head_q].valid && ent_q[head_q].store;
    assign squash        = retire[0] && slot_spec[0];

    always_comb begin
        for (int k = 0; k < COMMIT_W; k++) begin
            slot_idx[k]   = head_q + TAG_W'(k);
            slot_valid[k] = ent_q[slot_idx[k]].valid;
            slot_exec[k]  = ent_q[slot_idx[k]].executed;
            slot_spec[k]  = ent_q[slot_idx[k]].sys || ent_q[slot_idx[k]].redirect;
        end
    end

    rob_commit_select #(.COMMIT_W(COMMIT_W)) u_sel (
        .valid_i  (slot_valid),
        .exec_i   (slot_exec),
        .spec_i   (slot_spec),
        .retire_o (retire),
        .num_o    (retire_num)
    );

    always_comb begin
        ent_d = ent_q;
        head_d = head_q;
        tail_d = tail_q;
        count_d = count_q;
        commit_valid_d = '0;
        commit_reg_write_d = '0;
        commit_arch_d = '0;
        commit_phys_d = '0;
        commit_pc_d = '0;
        flush_out_d = 1'b0;
        mem_flush_d = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d = '0;
        wb_win = 1'b0;
        wb_t = '0;
        if (flush_in_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
                ent_d[i].executed = 1'b0;
                ent_d[i].redirect = 1'b0;
            end
            tail_d = head_q;
            count_d = '0;
        end else begin
            // A port is dropped when a lower-indexed port targets the same tag.
            for (int p = 0; p < WB_PORTS; p++) begin
                wb_t = wb_tag_i[p*TAG_W +: TAG_W];
                wb_win = wb_valid_i[p];
                for (int q = 0; q < p; q++)
                    if (wb_valid_i[q] && wb_tag_i[q*TAG_W +: TAG_W] == wb_t)
                        wb_win = 1'b0;
                if (wb_win && ent_q[wb_t].valid) begin
                    ent_d[wb_t].executed = 1'b1;
                    if (wb_redirect_i[p]) begin
                        ent_d[wb_t].redirect = 1'b1;
                        ent_d[wb_t].alt_pc = wb_alt_pc_i[p*PC_W +: PC_W];
                    end
                end
            end
            for (int k = 0; k < COMMIT_W; k++) begin
                if (retire[k]) begin
                    ent_d[slot_idx[k]].valid = 1'b0;
                    ent_d[slot_idx[k]].executed = 1'b0;
                    ent_d[slot_idx[k]].redirect = 1'b0;
                end
                commit_valid_d[k] = retire[k];
                commit_reg_write_d[k] = retire[k] && ent_q[slot_idx[k]].reg_write;
                commit_arch_d[k*ARCH_W +: ARCH_W] = retire[k] ? ent_q[slot_idx[k]].arch : '0;
                commit_phys_d[k*PHYS_W +: PHYS_W] = retire[k] ? ent_q[slot_idx[k]].phys : '0;
                commit_pc_d[k*PC_W +: PC_W] = retire[k] ? ent_q[slot_idx[k]].pc : '0;
            end
            head_d = head_q + TAG_W'(retire_num);
            if (alloc_fire) begin
                ent_d[tail_q] = '{valid: 1'b1, executed: alloc_sys_i, sys: alloc_sys_i,
                                  redirect: 1'b0, load: alloc_load_i, store: alloc_store_i,
                                  reg_write: alloc_reg_write_i, arch: alloc_arch_i,
                                  phys: alloc_phys_i, pc: alloc_pc_i, alt_pc: '0};
                tail_d = tail_q + TAG_W'(1);
            end
            count_d = count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire_num);
            // Sys/redirect retirement empties the buffer just past the retiring entry;
            // a same-cycle allocation is dropped with the rest.
            if (squash) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (TAG_W'(i) != head_q && ent_q[i].valid && (ent_q[i].load || ent_q[i].store))
                        mem_flush_d = 1'b1;
                    ent_d[i].valid = 1'b0;
                    ent_d[i].executed = 1'b0;
                    ent_d[i].redirect = 1'b0;
                end
                head_d = head_q + TAG_W'(1);
                tail_d = head_q + TAG_W'(1);
                count_d = '0;
                flush_out_d = 1'b1;
                redirect_valid_d = ent_q[head_q].redirect;
                redirect_pc_d = ent_q[head_q].redirect ? ent_q[head_q].alt_pc : '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                ent_q[i] <= '0;
            commit_valid_q <= '0;
            commit_reg_write_q <= '0;
            commit_arch_q <= '0;
            commit_phys_q <= '0;
            commit_pc_q <= '0;
            flush_out_q <= 1'b0;
            mem_flush_q <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
            ent_q <= ent_d;
            commit_valid_q <= commit_valid_d;
            commit_reg_write_q <= commit_reg_write_d;
            commit_arch_q <= commit_arch_d;
            commit_phys_q <= commit_phys_d;
            commit_pc_q <= commit_pc_d;
            flush_out_q <= flush_out_d;
            mem_flush_q <= mem_flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign commit_valid_o     = commit_valid_q;
    assign commit_reg_write_o = commit_reg_write_q;
    assign commit_arch_o      = commit_arch_q;
    assign commit_phys_o      = commit_phys_q;
    assign commit_pc_o        = commit_pc_q;
    assign flush_out_o        = flush_out_q;
    assign mem_flush_o        = mem_flush_q;
    assign redirect_valid_o   = redirect_valid_q;
    assign redirect_pc_o      = redirect_pc_q;

endmodule

// File: tb/tb_rob_multi_commit.sv
// tb_rob_multi_commit: directed bench for rob_multi_commit with an 8-entry buffer.
module tb_rob_multi_commit;

    logic        clk, rst;
    logic        alloc_valid, alloc_ready, alloc_reg_write, alloc_sys, alloc_load, alloc_store;
    logic [4:0]  alloc_arch;
    logic [5:0]  alloc_phys;
    logic [31:0] alloc_pc;
    logic [2:0]  alloc_tag;
    logic [1:0]  wb_valid, wb_redirect;
    logic [5:0]  wb_tag;
    logic [63:0] wb_alt_pc;
    logic [1:0]  commit_valid, commit_reg_write;
    logic [9:0]  commit_arch;
    logic [11:0] commit_phys;
    logic [63:0] commit_pc;
    logic        flush_in, flush_out, mem_flush, redirect_valid, head_store;
    logic [31:0] redirect_pc;
    logic [3:0]  count;
    int          n_chk = 0;
    int          n_fail = 0;

    rob_multi_commit #(.DEPTH(8), .COMMIT_W(2), .WB_PORTS(2)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .alloc_valid_i      (alloc_valid),
        .alloc_ready_o      (alloc_ready),
        .alloc_reg_write_i  (alloc_reg_write),
        .alloc_arch_i       (alloc_arch),
        .alloc_phys_i       (alloc_phys),
        .alloc_pc_i         (alloc_pc),
        .alloc_sys_i        (alloc_sys),
        .alloc_load_i       (alloc_load),
        .alloc_store_i      (alloc_store),
        .alloc_tag_o        (alloc_tag),
        .wb_valid_i         (wb_valid),
        .wb_tag_i           (wb_tag),
        .wb_redirect_i      (wb_redirect),
        .wb_alt_pc_i        (wb_alt_pc),
        .commit_valid_o     (commit_valid),
        .commit_reg_write_o (commit_reg_write),
        .commit_arch_o      (commit_arch),
        .commit_phys_o      (commit_phys),
        .commit_pc_o        (commit_pc),
        .flush_in_i         (flush_in),
        .flush_out_o        (flush_out),
        .mem_flush_o        (mem_flush),
        .redirect_valid_o   (redirect_valid),
        .redirect_pc_o      (redirect_pc),
        .head_store_o       (head_store),
        .count_o            (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        alloc_valid = 0; alloc_reg_write = 0; alloc_sys = 0; alloc_load = 0; alloc_store = 0;
        alloc_arch = '0; alloc_phys = '0; alloc_pc = '0;
        wb_valid = '0; wb_tag = '0; wb_redirect = '0; wb_alt_pc = '0;
        flush_in = 0;
    endtask

    task automatic do_reset();
        rst = 1; clr(); tick(); rst = 0;
    endtask

    task automatic alloc1(input logic [31:0] pc, input logic sys, input logic ld, input logic st);
        alloc_valid = 1; alloc_reg_write = 1; alloc_arch = pc[6:2]; alloc_phys = pc[7:2];
        alloc_pc = pc; alloc_sys = sys; alloc_load = ld; alloc_store = st;
        tick(); clr();
    endtask

    task automatic set_wb(input int p, input logic [2:0] t, input logic rd, input logic [31:0] alt);
        wb_valid[p] = 1; wb_tag[p*3 +: 3] = t; wb_redirect[p] = rd; wb_alt_pc[p*32 +: 32] = alt;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " ready"}, alloc_ready, 1);
        chk({tag, " tag"}, alloc_tag, 0);
        chk({tag, " count"}, count, 0);
        chk({tag, " cv"}, commit_valid, 0);
        chk({tag, " crw"}, commit_reg_write, 0);
        chk({tag, " carch"}, commit_arch, 0);
        chk({tag, " cphys"}, commit_phys, 0);
        chk({tag, " cpc"}, commit_pc, 0);
        chk({tag, " flush"}, flush_out, 0);
        chk({tag, " memflush"}, mem_flush, 0);
        chk({tag, " rv"}, redirect_valid, 0);
        chk({tag, " rpc"}, redirect_pc, 0);
        chk({tag, " hstore"}, head_store, 0);
    endtask

    initial begin
        do_reset();
        chk_reset_state("rst");

        // ordered retirement: writebacks arrive youngest first
        for (int i = 0; i < 4; i++) begin
            chk("t1 tag", alloc_tag, i);
            alloc1(32'h100 + 4*i, 0, 0, 0);
        end
        chk("t1 count", count, 4);
        for (int t = 3; t >= 0; t--) begin
            set_wb(0, 3'(t), 0, 0);
            tick(); clr();
            chk("t1 no commit", commit_valid, 0);
        end
        tick();
        chk("t1 cv01", commit_valid, 2'b11);
        chk("t1 pc01", commit_pc, {32'h104, 32'h100});
        chk("t1 arch01", commit_arch, {5'd1, 5'd0});
        chk("t1 phys01", commit_phys, {6'd1, 6'd0});
        chk("t1 rw01", commit_reg_write, 2'b11);
        chk("t1 count2", count, 2);
        tick();
        chk("t1 cv23", commit_valid, 2'b11);
        chk("t1 pc23", commit_pc, {32'h10c, 32'h108});
        chk("t1 count0", count, 0);
        tick();
        chk("t1 idle", commit_valid, 0);

        // full and wrap
        do_reset();
        for (int i = 0; i < 8; i++) begin
            chk("t2 tag", alloc_tag, i);
            alloc1(32'h100 + 4*i, 0, 0, i == 0);
        end
        chk("t2 ready full", alloc_ready, 0);
        chk("t2 count full", count, 8);
        chk("t2 tag wrap", alloc_tag, 0);
        chk("t2 hstore", head_store, 1);
        alloc1(32'h400, 0, 0, 0);
        chk("t2 count hold", count, 8);
        chk("t2 tag hold", alloc_tag, 0);
        set_wb(0, 0, 0, 0); set_wb(1, 1, 0, 0);
        tick(); clr();
        chk("t2 no commit", commit_valid, 0);
        tick();
        chk("t2 cv", commit_valid, 2'b11);
        chk("t2 count6", count, 6);
        chk("t2 ready", alloc_ready, 1);
        chk("t2 tag0", alloc_tag, 0);
        chk("t2 hstore0", head_store, 0);
        alloc1(32'h500, 0, 0, 0);
        chk("t2 count7", count, 7);
        chk("t2 tag1", alloc_tag, 1);
        chk("t2 cv idle", commit_valid, 0);

        // redirect with a younger load squashed
        do_reset();
        for (int i = 0; i < 5; i++) alloc1(32'h100 + 4*i, 0, i == 3, 0);
        set_wb(0, 0, 0, 0); set_wb(1, 1, 1, 32'h1000);
        tick(); clr();
        chk("t3 no commit", commit_valid, 0);
        tick();
        chk("t3 cv0", commit_valid, 2'b01);
        chk("t3 pc0", commit_pc[31:0], 32'h100);
        chk("t3 count4", count, 4);
        chk("t3 noflush", flush_out, 0);
        tick();
        chk("t3 cv1", commit_valid, 2'b01);
        chk("t3 pc1", commit_pc[31:0], 32'h104);
        chk("t3 rv", redirect_valid, 1);
        chk("t3 rpc", redirect_pc, 32'h1000);
        chk("t3 flush", flush_out, 1);
        chk("t3 memflush", mem_flush, 1);
        chk("t3 count0", count, 0);
        chk("t3 ready0", alloc_ready, 0);
        tick();
        chk("t3 flush off", flush_out, 0);
        chk("t3 rv off", redirect_valid, 0);
        chk("t3 ready1", alloc_ready, 1);
        chk("t3 tag", alloc_tag, 2);
        chk("t3 cv off", commit_valid, 0);

        // sys retires without writeback
        alloc1(32'h200, 1, 0, 0);
        chk("t4 count1", count, 1);
        chk("t4 no commit", commit_valid, 0);
        tick();
        chk("t4 cv", commit_valid, 2'b01);
        chk("t4 pc", commit_pc[31:0], 32'h200);
        chk("t4 flush", flush_out, 1);
        chk("t4 rv", redirect_valid, 0);
        chk("t4 memflush", mem_flush, 0);
        chk("t4 count0", count, 0);
        tick();
        chk("t4 flush off", flush_out, 0);
        chk("t4 tag", alloc_tag, 3);

        // dual-port collision on tag 5: port 0 (no redirect) wins
        do_reset();
        for (int i = 0; i < 6; i++) alloc1(32'h100 + 4*i, 0, 0, 0);
        set_wb(0, 5, 0, 32'haaaa); set_wb(1, 5, 1, 32'hbbbb);
        tick(); clr();
        chk("t5 no commit a", commit_valid, 0);
        set_wb(0, 0, 0, 0); set_wb(1, 1, 0, 0);
        tick(); clr();
        chk("t5 no commit b", commit_valid, 0);
        set_wb(0, 2, 0, 0); set_wb(1, 3, 0, 0);
        tick(); clr();
        chk("t5 cv01", commit_valid, 2'b11);
        chk("t5 pc01", commit_pc, {32'h104, 32'h100});
        chk("t5 count4", count, 4);
        set_wb(0, 4, 0, 0);
        tick(); clr();
        chk("t5 cv23", commit_valid, 2'b11);
        chk("t5 count2", count, 2);
        tick();
        chk("t5 cv45", commit_valid, 2'b11);
        chk("t5 pc45", commit_pc, {32'h114, 32'h110});
        chk("t5 flush", flush_out, 0);
        chk("t5 rv", redirect_valid, 0);
        chk("t5 count0", count, 0);
        tick();
        chk("t5 rv after", redirect_valid, 0);
        chk("t5 flush after", flush_out, 0);
        chk("t5 cv after", commit_valid, 0);

        // flush_in beats same-cycle alloc and commit
        chk("t6 tag6", alloc_tag, 6);
        alloc1(32'h300, 0, 0, 0);
        alloc1(32'h304, 0, 0, 0);
        set_wb(0, 6, 0, 0); set_wb(1, 7, 0, 0);
        tick(); clr();
        chk("t6 count2", count, 2);
        chk("t6 no commit", commit_valid, 0);
        flush_in = 1; alloc_valid = 1; alloc_pc = 32'h308;
        tick(); clr();
        chk("t6 count0", count, 0);
        chk("t6 cv", commit_valid, 0);
        chk("t6 flush_out", flush_out, 0);
        chk("t6 tag", alloc_tag, 6);
        chk("t6 ready", alloc_ready, 1);
        tick();
        chk("t6 cv later", commit_valid, 0);
        chk("t6 count later", count, 0);

        // reset with six entries in flight overrides flush_in and alloc
        alloc1(32'h400, 0, 0, 1);
        chk("t7 hstore", head_store, 1);
        for (int i = 1; i < 6; i++) alloc1(32'h400 + 4*i, 0, 0, 0);
        chk("t7 count6", count, 6);
        set_wb(0, 6, 0, 0); set_wb(1, 7, 0, 0);
        tick(); clr();
        rst = 1; alloc_valid = 1; alloc_pc = 32'h500; flush_in = 1;
        set_wb(0, 0, 1, 32'hdead);
        tick(); rst = 0; clr();
        chk_reset_state("t7");
        tick();
        chk("t7 cv later", commit_valid, 0);
        chk("t7 count later", count, 0);
        chk("t7 tag later", alloc_tag, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
